// File: rtl/riscv_data_mem_sb.sv
// Data-memory slave with a posted-store FIFO buffer drained into a word array on load-free cycles.
// Loads are answered combinationally, forwarding from the youngest matching buffered store.
module riscv_data_mem_sb #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned SB_DEPTH    = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             mem_read,
   input  logic                             mem_write,
   input  logic [31:0]                      data_mem_addr,
   input  logic [31:0]                      data_mem_wdata,
   output logic [31:0]                      data_mem_rdata,
   output logic                             mem_stall,
   output logic                             misaligned,
   output logic [$clog2(SB_DEPTH+1)-1:0]    sb_count,
   output logic                             sb_empty
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam int unsigned PW = $clog2(SB_DEPTH);
   localparam int unsigned CW = $clog2(SB_DEPTH + 1);

   logic [31:0]   array [DEPTH_WORDS];
   logic [AW-1:0] sb_idx [SB_DEPTH];
   logic [31:0]   sb_data [SB_DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;
   logic          sb_empty_q;

   logic [AW-1:0] idx;
   logic          full;
   logic          enq;
   logic          drain;
   logic          fwd_hit;
   logic [31:0]   fwd_data;
   logic [PW-1:0] pos;
   logic          unused_addr_hi;

   assign idx            = data_mem_addr[AW+1:2];
   assign unused_addr_hi = ^data_mem_addr[31:AW+2];
   assign full           = (count == CW'(SB_DEPTH));
   assign mem_stall      = mem_write && mem_read && full;
   assign enq            = mem_write && !mem_stall;
   assign drain          = (count != '0) && !mem_read;
   assign misaligned     = (mem_read || mem_write) && (data_mem_addr[1:0] != 2'b00);
   assign sb_count       = count;
   assign sb_empty       = sb_empty_q;

   // Walk entries oldest to youngest so the last match seen is the youngest.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      pos      = '0;
      for (int k = 0; k < int'(SB_DEPTH); k++) begin
         pos = head + PW'(k);
         if ((CW'(k) < count) && (sb_idx[pos] == idx)) begin
            fwd_hit  = 1'b1;
            fwd_data = sb_data[pos];
         end
      end
   end

   always_comb begin
      data_mem_rdata = '0;
      if (mem_read) begin
         data_mem_rdata = fwd_hit ? fwd_data : array[idx];
      end
   end

   always_comb begin
      count_nxt = count;
      case ({enq, drain})
         2'b10:   count_nxt = count + CW'(1);
         2'b01:   count_nxt = count - CW'(1);
         default: count_nxt = count;
      endcase
   end

   // Buffer control; payload slots need no reset because count gates them.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         sb_empty_q <= 1'b1;
      end else begin
         if (drain) head <= head + PW'(1);
         if (enq)   tail <= tail + PW'(1);
         count      <= count_nxt;
         sb_empty_q <= (count_nxt == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         sb_idx[tail]  <= idx;
         sb_data[tail] <= data_mem_wdata;
      end
   end

   // On a full buffer with enqueue+drain, tail==head; the drain reads the old slot value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(DEPTH_WORDS); i++) array[i] <= '0;
      end else if (drain) begin
         array[sb_idx[head]] <= sb_data[head];
      end
   end

endmodule
